aes_run_ctrl: RTL and testbench

Sequencer between the local-bus register interface and the AES block-cipher core on the SASEBO-GIII target. It accepts key-load and run commands and drives the core's Krdy/Drdy/Kvld/Dvld/BSY handshake. A run can encrypt a batch of blocks, optionally chained so that each ciphertext becomes the next plaintext. It also drives the scope trigger, a response watchdog, and core-reset recovery.

---
 rtl/aes_ctrl_pkg.sv | 19 +
 rtl/ctrl_wdog.sv | 31 +++
 rtl/aes_run_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_aes_run_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES run controller.
//   BLK_W        cipher block and key width
//   RECOVER_LEN  number of cycles the core reset is held low after a timeout
//   ctrl_state_e sequencer states
package aes_ctrl_pkg;

    localparam int unsigned BLK_W       = 128;
    localparam int unsigned RECOVER_LEN = 4;

    typedef enum logic [2:0] {
        StIdle,
        StKeyReq,
        StKeyWait,
        StDatReq,
        StDatWait,
        StRecover
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_wdog.sv
// Response watchdog for the AES core handshake.
//   clk, rst  clock and synchronous active-high reset
//   clear     zero the count (held while not waiting on the core)
//   enable    count one wait cycle
//   expired   high in the wait cycle in which the count reaches all-ones
module ctrl_wdog #(
    parameter int unsigned TMO_W = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // One below all-ones: the increment at the end of this cycle would saturate.
    localparam logic [TMO_W-1:0] LAST = ~(TMO_W'(1));

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/aes_run_ctrl.sv
// Sequencer between the local-bus registers and the AES core.
// Accepts key-load and run commands, drives the core Krdy/Drdy handshake,
// runs batches of blocks (optionally chained), and recovers the core on timeout.
//   cmd_key/cmd_run      one-cycle command pulses (ignored while busy)
//   key_in/pt_in/run_cnt/chain  command operands, sampled with the command
//   busy/done/err        status; done is a one-cycle pulse, err is sticky
//   ct_out/done_cnt      last ciphertext and number of blocks completed
//   trig                 scope trigger, coincident with blk_drdy
//   blk_*                AES core interface (blk_rstn active low)
module aes_run_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_key,
    input  logic             cmd_run,
    input  logic [BLK_W-1:0] key_in,
    input  logic [BLK_W-1:0] pt_in,
    input  logic [CNT_W-1:0] run_cnt,
    input  logic             chain,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BLK_W-1:0] ct_out,
    output logic [CNT_W-1:0] done_cnt,
    output logic             trig,
    output logic [BLK_W-1:0] blk_kin,
    output logic [BLK_W-1:0] blk_din,
    output logic             blk_krdy,
    output logic             blk_drdy,
    output logic             blk_rstn,
    input  logic             blk_kvld,
    input  logic             blk_dvld,
    input  logic             blk_bsy,
    input  logic [BLK_W-1:0] blk_dout
);

    localparam int unsigned      REC_W    = $clog2(RECOVER_LEN);
    localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_LEN - 1);

    ctrl_state_e      state_q, state_d;
    logic             key_ok_q, key_ok_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [BLK_W-1:0] ct_q, ct_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [BLK_W-1:0] kin_q, kin_d;
    logic [BLK_W-1:0] din_q, din_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             chain_q, chain_d;
    logic             pend_q, pend_d;   // run queued behind a same-cycle key load
    logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
    logic [CNT_W-1:0] done_cnt_inc;
    logic             wd_en, wd_expired;

    assign wd_en        = (state_q == StKeyWait) || (state_q == StDatWait);
    assign done_cnt_inc = done_cnt_q + 1'b1;

    ctrl_wdog #(
        .TMO_W(TMO_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!wd_en),
        .enable (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        key_ok_d   = key_ok_q;
        err_d      = err_q;
        done_d     = 1'b0;
        ct_d       = ct_q;
        done_cnt_d = done_cnt_q;
        kin_d      = kin_q;
        din_d      = din_q;
        run_cnt_d  = run_cnt_q;
        chain_d    = chain_q;
        pend_d     = pend_q;
        rec_cnt_d  = rec_cnt_q;

        case (state_q)
            StIdle: begin
                if (cmd_key) begin
                    state_d = StKeyReq;
                    err_d   = 1'b0;
                    kin_d   = key_in;
                    pend_d  = cmd_run;
                    if (cmd_run) begin
                        din_d     = pt_in;
                        run_cnt_d = run_cnt;
                        chain_d   = chain;
                    end
                end else if (cmd_run) begin
                    if (!key_ok_q) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (run_cnt == '0) begin
                        err_d      = 1'b0;
                        done_d     = 1'b1;
                        done_cnt_d = '0;
                    end else begin
                        state_d    = StDatReq;
                        err_d      = 1'b0;
                        done_cnt_d = '0;
                        din_d      = pt_in;
                        run_cnt_d  = run_cnt;
                        chain_d    = chain;
                    end
                end
            end
            StKeyReq: state_d = StKeyWait;
            StKeyWait: begin
                if (blk_kvld) begin
                    key_ok_d = 1'b1;
                    pend_d   = 1'b0;
                    if (pend_q) begin
                        done_cnt_d = '0;
                    end
                    if (pend_q && (run_cnt_q != '0)) begin
                        state_d = StDatReq;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d   = StRecover;
                    err_d     = 1'b1;
                    key_ok_d  = 1'b0;
                    pend_d    = 1'b0;
                    rec_cnt_d = '0;
                end
            end
            StDatReq: begin
                if (!blk_bsy) begin
                    state_d = StDatWait;
                end
            end
            StDatWait: begin
                // A response in the saturating cycle wins over the timeout.
                if (blk_dvld) begin
                    ct_d       = blk_dout;
                    done_cnt_d = done_cnt_inc;
                    if (chain_q) begin
                        din_d = blk_dout;
                    end
                    if (done_cnt_inc == run_cnt_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StDatReq;
                    end
                end else if (wd_expired) begin
                    state_d   = StRecover;
                    err_d     = 1'b1;
                    key_ok_d  = 1'b0;
                    rec_cnt_d = '0;
                end
            end
            StRecover: begin
                if (rec_cnt_q == REC_LAST) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    rec_cnt_d = rec_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            key_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            ct_q       <= '0;
            done_cnt_q <= '0;
            kin_q      <= '0;
            din_q      <= '0;
            run_cnt_q  <= '0;
            chain_q    <= 1'b0;
            pend_q     <= 1'b0;
            rec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            key_ok_q   <= key_ok_d;
            err_q      <= err_d;
            done_q     <= done_d;
            ct_q       <= ct_d;
            done_cnt_q <= done_cnt_d;
            kin_q      <= kin_d;
            din_q      <= din_d;
            run_cnt_q  <= run_cnt_d;
            chain_q    <= chain_d;
            pend_q     <= pend_d;
            rec_cnt_q  <= rec_cnt_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign err      = err_q;
    assign ct_out   = ct_q;
    assign done_cnt = done_cnt_q;
    assign blk_kin  = kin_q;
    assign blk_din  = din_q;
    assign blk_krdy = (state_q == StKeyReq);
    assign blk_drdy = (state_q == StDatReq) && !blk_bsy;
    assign trig     = blk_drdy;
    assign blk_rstn = (state_q != StRecover);

endmodule

// File: tb/tb_aes_run_ctrl.sv
// Self-checking bench for aes_run_ctrl with a behavioural AES core model.
module tb_aes_run_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMO_W = 12;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst, cmd_key, cmd_run, chain;
    logic [127:0] key_in, pt_in;
    logic [CNT_W-1:0] run_cnt;
    logic busy, done, err, trig, blk_krdy, blk_drdy, blk_rstn;
    logic [127:0] ct_out, blk_kin, blk_din, blk_dout;
    logic [CNT_W-1:0] done_cnt;
    logic blk_kvld, blk_dvld, blk_bsy;

    aes_run_ctrl #(
        .CNT_W(CNT_W),
        .TMO_W(TMO_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_key (cmd_key),
        .cmd_run (cmd_run),
        .key_in  (key_in),
        .pt_in   (pt_in),
        .run_cnt (run_cnt),
        .chain   (chain),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .ct_out  (ct_out),
        .done_cnt(done_cnt),
        .trig    (trig),
        .blk_kin (blk_kin),
        .blk_din (blk_din),
        .blk_krdy(blk_krdy),
        .blk_drdy(blk_drdy),
        .blk_rstn(blk_rstn),
        .blk_kvld(blk_kvld),
        .blk_dvld(blk_dvld),
        .blk_bsy (blk_bsy),
        .blk_dout(blk_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in cipher: the FIPS-197 vector maps to its known ciphertext, anything
    // else goes through a cheap mixing function so chained blocks stay distinct.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
        if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
        return {d[94:0], d[127:95]} ^ k ^ 128'h5a5a_1234_c3c3_8765_0f0f_abcd_9696_4321;
    endfunction

    // Core model configuration and state
    int core_lat = 10;
    int core_tail = 0;
    logic core_dead = 1'b0;
    logic [127:0] core_key = '0, core_din = '0;

    initial begin
        logic saw_k, saw_d, saw_rlow;
        logic [127:0] kin_s, din_s;
        int k_t, d_t, tail_t;
        blk_kvld = 1'b0; blk_dvld = 1'b0; blk_bsy = 1'b0; blk_dout = '0;
        k_t = 0; d_t = 0; tail_t = 0;
        forever begin
            @(negedge clk);
            saw_k = blk_krdy; saw_d = blk_drdy; saw_rlow = !blk_rstn;
            kin_s = blk_kin; din_s = blk_din;
            @(posedge clk);
            #1;
            blk_kvld = 1'b0;
            blk_dvld = 1'b0;
            if (saw_rlow) begin
                k_t = 0; d_t = 0; tail_t = 0; blk_bsy = 1'b0;
            end else begin
                if (k_t > 0) begin
                    k_t--;
                    if (k_t == 0) blk_kvld = 1'b1;
                end
                if (d_t > 0) begin
                    d_t--;
                    if (d_t == 0) begin
                        blk_dvld = 1'b1;
                        blk_dout = core_fn(core_key, core_din);
                        tail_t = core_tail;
                        blk_bsy = (core_tail != 0);
                    end
                end else if (tail_t > 0) begin
                    tail_t--;
                    blk_bsy = (tail_t != 0);
                end
                if (!core_dead) begin
                    if (saw_k) begin core_key = kin_s; k_t = core_lat - 1; end
                    if (saw_d) begin core_din = din_s; d_t = core_lat - 1; blk_bsy = 1'b1; end
                end
            end
        end
    end

    // Event logs, stamped with the cycle number
    int drdy_cyc[$], dvld_cyc[$], krdy_cyc[$], kvld_cyc[$], done_cyc[$], rstn_cyc[$];
    logic [127:0] drdy_din[$];
    int trig_bad = 0, stab_bad = 0;

    always @(negedge clk) begin
        if (done) done_cyc.push_back(cyc);
        if (blk_drdy) begin drdy_cyc.push_back(cyc); drdy_din.push_back(blk_din); end
        if (blk_krdy) krdy_cyc.push_back(cyc);
        if (blk_dvld) dvld_cyc.push_back(cyc);
        if (blk_kvld) kvld_cyc.push_back(cyc);
        if (!blk_rstn) rstn_cyc.push_back(cyc);
        if (trig !== blk_drdy) trig_bad++;
        if (blk_dvld && blk_din !== core_din) stab_bad++;
        if (blk_kvld && blk_kin !== core_key) stab_bad++;
    end

    task automatic clear_logs();
        drdy_cyc.delete(); dvld_cyc.delete(); krdy_cyc.delete(); kvld_cyc.delete();
        done_cyc.delete(); rstn_cyc.delete(); drdy_din.delete();
        trig_bad = 0; stab_bad = 0;
    endtask

    // Reference state
    logic [127:0] m_key = '0, m_ct = '0;
    logic m_key_ok = 1'b0, m_err = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    int cmd_cyc;

    task automatic issue(input logic k, input logic r, input logic [127:0] kv,
                         input logic [127:0] pv, input logic [CNT_W-1:0] n, input logic ch);
        @(negedge clk);
        cmd_key = k; cmd_run = r; key_in = kv; pt_in = pv; run_cnt = n; chain = ch;
        cmd_cyc = cyc;
    endtask

    // Waits for the done pulse; optionally pokes a cmd_run while the DUT is busy.
    task automatic wait_done(input string tag, input int budget, input logic poke);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            cmd_key = 1'b0;
            cmd_run = (poke && i == 3);
            if (cmd_run) pt_in = 128'hdead_beef;
            seen = done;
        end
        cmd_run = 1'b0;
        check_eq({tag, " done_seen"}, seen, 1'b1);
    endtask

    task automatic exec(input string tag, input logic k, input logic r, input logic [127:0] kv,
                        input logic [127:0] pv, input logic [CNT_W-1:0] n, input logic ch,
                        input logic poke);
        logic [127:0] exp_din[$];
        logic [127:0] d, c;
        if (k) begin m_key = kv; m_key_ok = 1'b1; m_err = 1'b0; end
        if (r) begin
            if (!m_key_ok) begin
                m_err = 1'b1;
            end else begin
                m_err = 1'b0;
                m_cnt = n;
                d = pv;
                for (int i = 0; i < int'(n); i++) begin
                    exp_din.push_back(d);
                    c = core_fn(m_key, d);
                    if (ch) d = c;
                    m_ct = c;
                end
            end
        end
        clear_logs();
        issue(k, r, kv, pv, n, ch);
        wait_done(tag, 600, poke);
        repeat (3) @(negedge clk);
        check_eq({tag, " ct_out"}, ct_out, m_ct);
        check_eq({tag, " done_cnt"}, done_cnt, m_cnt);
        check_eq({tag, " err"}, err, m_err);
        check_eq({tag, " busy"}, busy, 1'b0);
        check_eq({tag, " done_pulses"}, done_cyc.size(), 1);
        check_eq({tag, " krdy_count"}, krdy_cyc.size(), k);
        check_eq({tag, " drdy_count"}, drdy_din.size(), exp_din.size());
        for (int i = 0; i < exp_din.size() && i < drdy_din.size(); i++)
            check_eq({tag, " blk_din"}, drdy_din[i], exp_din[i]);
        check_eq({tag, " trig"}, trig_bad, 0);
        check_eq({tag, " kin_din_stable"}, stab_bad, 0);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " busy"}, busy, 1'b0);
        check_eq({tag, " done"}, done, 1'b0);
        check_eq({tag, " err"}, err, 1'b0);
        check_eq({tag, " trig"}, trig, 1'b0);
        check_eq({tag, " krdy"}, blk_krdy, 1'b0);
        check_eq({tag, " drdy"}, blk_drdy, 1'b0);
        check_eq({tag, " rstn"}, blk_rstn, 1'b1);
        check_eq({tag, " ct_out"}, ct_out, '0);
        check_eq({tag, " done_cnt"}, done_cnt, '0);
        check_eq({tag, " kin"}, blk_kin, '0);
        check_eq({tag, " din"}, blk_din, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [127:0] kv, pv;
        logic k, r, ch;
        logic [CNT_W-1:0] n;
        int sel;

        rst = 1'b1; cmd_key = 1'b0; cmd_run = 1'b0; chain = 1'b0;
        key_in = '0; pt_in = '0; run_cnt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Run without a key: error, done the next cycle, no core activity.
        exec("nokey", 1'b0, 1'b1, '0, FIPS_PT, 1, 1'b0, 1'b0);
        if (done_cyc.size() > 0) check_eq("nokey done_latency", done_cyc[0] - cmd_cyc, 1);

        exec("key", 1'b1, 1'b0, FIPS_KEY, '0, 0, 1'b0, 1'b0);
        if (krdy_cyc.size() > 0) check_eq("key krdy_latency", krdy_cyc[0] - cmd_cyc, 1);

        exec("single", 1'b0, 1'b1, '0, FIPS_PT, 1, 1'b0, 1'b0);
        check_eq("single fips_ct", ct_out, FIPS_CT);
        if (drdy_cyc.size() > 0 && dvld_cyc.size() > 0 && done_cyc.size() > 0) begin
            check_eq("single drdy_latency", drdy_cyc[0] - cmd_cyc, 1);
            check_eq("single core_latency", dvld_cyc[0] - drdy_cyc[0], 10);
            check_eq("single done_after_dvld", done_cyc[0] - dvld_cyc[0], 1);
        end

        exec("chain", 1'b0, 1'b1, '0, FIPS_PT, 3, 1'b1, 1'b0);
        if (drdy_din.size() == 3 && dvld_cyc.size() == 3 && done_cyc.size() > 0) begin
            check_eq("chain din2_is_ct1", drdy_din[1], FIPS_CT);
            for (int i = 1; i < 3; i++)
                check_eq("chain block_overhead", drdy_cyc[i] - dvld_cyc[i-1] + 1, 2);
            check_eq("chain done_after_dvld", done_cyc[0] - dvld_cyc[2], 1);
        end

        exec("cnt0", 1'b0, 1'b1, '0, FIPS_PT, 0, 1'b0, 1'b0);
        if (done_cyc.size() > 0) check_eq("cnt0 done_latency", done_cyc[0] - cmd_cyc, 1);

        // Key and run together, with a stray cmd_run while busy.
        exec("keyrun", 1'b1, 1'b1, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
             128'h3243f6a8_885a308d_313198a2_e0370734, 2, 1'b0, 1'b1);
        if (kvld_cyc.size() > 0 && drdy_cyc.size() > 0 && done_cyc.size() > 0) begin
            check_eq("keyrun drdy_after_kvld", drdy_cyc[0] - kvld_cyc[0], 1);
            check_eq("keyrun done_after_drdy", done_cyc[0] > drdy_cyc[drdy_cyc.size()-1], 1'b1);
        end

        // Dead core: watchdog, core reset for 4 cycles, then done with err.
        core_dead = 1'b1;
        clear_logs();
        issue(1'b0, 1'b1, '0, FIPS_PT, 1, 1'b0);
        wait_done("wdog", 6000, 1'b0);
        repeat (3) @(negedge clk);
        core_dead = 1'b0;
        m_key_ok = 1'b0; m_err = 1'b1; m_cnt = '0;
        check_eq("wdog err", err, 1'b1);
        check_eq("wdog done_cnt", done_cnt, m_cnt);
        check_eq("wdog rstn_low_cycles", rstn_cyc.size(), 4);
        check_eq("wdog drdy_count", drdy_cyc.size(), 1);
        if (rstn_cyc.size() == 4 && drdy_cyc.size() == 1 && done_cyc.size() == 1) begin
            check_eq("wdog wait_cycles", rstn_cyc[0] - drdy_cyc[0] - 1, (1 << TMO_W) - 1);
            check_eq("wdog rstn_contiguous", rstn_cyc[3] - rstn_cyc[0], 3);
            check_eq("wdog done_after_recover", done_cyc[0] - rstn_cyc[3], 1);
        end

        exec("after_wdog", 1'b0, 1'b1, '0, FIPS_PT, 1, 1'b0, 1'b0);

        exec("reload", 1'b1, 1'b0, FIPS_KEY, '0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            kv = {$urandom, $urandom, $urandom, $urandom};
            pv = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 9);
            k = (sel < 2) || (sel >= 8);
            r = (sel >= 2);
            ch = 1'($urandom_range(0, 1));
            n = CNT_W'($urandom_range(1, 4));
            if (sel == 3 && !m_err) n = '0;
            core_lat = $urandom_range(2, 8);
            core_tail = $urandom_range(0, 3);
            exec("rnd", k, r, kv, pv, n, ch, 1'($urandom_range(0, 1)));
        end
        core_lat = 10;
        core_tail = 0;

        // Reset during DAT_WAIT, then a late response that must be ignored.
        clear_logs();
        issue(1'b0, 1'b1, '0, FIPS_PT, 1, 1'b0);
        for (int i = 0; i < 20 && drdy_cyc.size() == 0; i++) begin
            @(negedge clk);
            cmd_run = 1'b0;
        end
        cmd_run = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("midrst late_dvld_arrived", dvld_cyc.size(), 1);
        check_eq("midrst ct_out", ct_out, '0);
        check_eq("midrst done_cnt", done_cnt, '0);
        check_eq("midrst done_pulses", done_cyc.size(), 0);
        check_eq("midrst busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
